sprite_line_engine: RTL and testbench
=====================================

Name: sprite_line_engine

Overview:
- Parametrised successor to the fixed-function sprite layer.
- Per scanline, scans the sprite attribute RAM and selects the sprites that hit the next line. For each hit it fetches pattern ROM rows through a req/valid handshake and draws the non-transparent pixels into the back half of a double line buffer.
- Streams the front half to the mixer and clears it as it is read.
- Adds a configurable sprite count, plane count, per-line cap, horizontal flip and an overflow flag.

Parameters:
- NUM_SPRITES, 64, sprites in attribute RAM (power of 2, 4 bytes each).
- PLANES, 4, bitplanes per pixel (1..8); ROM data width PLANES*8.
- COLOR_W, 4, palette-select bits per sprite.
- HPOS_W, 9, horizontal position width; line buffer depth 2^HPOS_W.
- MAX_PER_LINE, 16, sprites drawn per line before overflow.

Ports:
- pixel_clk, in, 1, sole clock.
- SPR_ROM_ADDR_RST, in, 1, reset, asynchronous, active-high.
- line_start, in, 1, one-cycle pulse at end of active line.
- vline, in, 8, line number to be prepared next; sampled on line_start.
- attr_addr, out, log2(NUM_SPRITES)+2, attribute RAM byte address.
- attr_data, in, 8, attribute byte; valid one cycle after attr_addr.
- rom_req, out, 1, pattern fetch request.
- rom_addr, out, 15, {idx[9:0], row[3:0], half}.
- rom_valid, in, 1, rom_data valid; completes the fetch.
- rom_data, in, PLANES*8, plane p in bits [8p+7:8p]; bit 7 is the leftmost pixel.
- hpix, in, HPOS_W, read-out position of the front buffer.
- pixel_out, out, PLANES+COLOR_W, {color, planes}; 0 = transparent.
- busy, out, 1, a scan or draw is in progress.
- overflow, out, 1, the line being displayed was truncated.

Behaviour:
- Reset values: pixel_out=0, busy=0, overflow=0, rom_req=0, attr_addr=0, state IDLE, front-buffer select=0. Line buffer contents are undefined until one full hpix sweep has cleared them.
- Attribute layout per sprite n at bytes 4n..4n+3:
  - byte 0: VPOS.
  - byte 1: IDX[7:0].
  - byte 2: XDAT, with [0]=HPOS[8], [4:1]=color, [5]=hflip, [7:6]=IDX[9:8].
  - byte 3: HPOS[7:0].
  - Color is truncated or zero-extended to COLOR_W; HPOS is truncated to HPOS_W.
- On line_start, in any state:
  - Swap the front/back select.
  - Latch overflow from the line just built.
  - Latch vline.
  - Reset the sprite pointer and hit count.
  - Enter RD_VPOS with busy=1.
  - If a scan was still running, it is aborted and the overflow latched in this same swap is 1.
- FSM: IDLE -> RD_VPOS -> RD_IDX -> RD_XDAT -> RD_HPOS -> CHECK -> (FETCH -> DRAW) x2 -> NEXT -> RD_VPOS | DONE -> IDLE.
  - Each RD_* state issues one address and captures the byte one cycle later (2 cycles per byte).
- CHECK:
  - diff = (vline - VPOS) mod 256.
  - Hit if diff < 16; row = diff[3:0].
  - A miss goes to NEXT.
  - A hit when hit count = MAX_PER_LINE sets the pending overflow and goes to DONE.
- FETCH:
  - Raise rom_req with rom_addr stable; half = 0 first, or 1 first when hflip=1.
  - Hold until rom_valid, capture rom_data in that cycle, drop rom_req the next cycle.
  - rom_valid without rom_req is ignored.
- DRAW: 8 cycles, pixel i = 0..7.
  - Plane bits are taken from bit 7-i; with hflip=1, from bit i.
  - Write address = (HPOS + 8*k + i) mod 2^HPOS_W, where k = fetch ordinal 0/1. Wrap-around is allowed.
  - An all-zero plane value is not written.
  - Otherwise write {color, planes}; a later sprite index overwrites an earlier one.
- NEXT: increment the pointer; after sprite NUM_SPRITES-1 go to DONE.
- DONE: clear busy.
- Read-out, every cycle independent of the FSM:
  - pixel_out <= front[hpix], a one-cycle registered read.
  - front[hpix] <= 0 in the same cycle.
  - The back buffer is never read.
- Reset asserted mid-scan: abort immediately and return all outputs to their reset values.

Test Plan:
- Reset, then sprite 0 = {VPOS=0x20, IDX=0x005, XDAT=0x02, HPOS=0x10}, line_start with vline=0x23, ROM returning plane0=0xFF, others 0, rom_valid after 3 cycles → rom_addr=0x00A6 then 0x00A7. After the next line_start, hpix 0x10..0x1F gives pixel_out=0x11; hpix 0x0F and 0x20 give 0.
- Same sprite with XDAT bit5=1 and plane0=0x80 on both fetches → first rom_addr half=1. After the swap, pixels appear at hpix 0x17 and 0x1F only.
- Two sprites at the same HPOS, colors 1 and 2, both opaque → pixel_out color field=2; with sprite 1 fully transparent → color 1.
- HPOS=0x1FC, XDAT[0]=1, opaque row → pixels at 0x1FC..0x1FF and 0x000..0x00B.
- 20 hits on one line with MAX_PER_LINE=16 → exactly 16 sprites drawn; overflow=1 for the line after the swap, and 0 on the following clean line.
- line_start pulsed 40 cycles into a scan → scan restarts at attr_addr=0, overflow=1. A second read of the same hpix within a line returns 0 (clear-on-read).

Source files
------------

// File: rtl/sprite_line_engine_if.sv
// Memory-side bus of the sprite line engine: attribute RAM read port and
// pattern ROM req/valid fetch channel.
interface sprite_line_engine_if #(
  parameter int AW     = 8,
  parameter int PLANES = 4
);
  logic [AW-1:0]         attr_addr;
  logic [7:0]            attr_data;
  logic                  rom_req;
  logic [14:0]           rom_addr;
  logic                  rom_valid;
  logic [PLANES*8-1:0]   rom_data;

  modport master (
    output attr_addr, rom_req, rom_addr,
    input  attr_data, rom_valid, rom_data
  );
  modport slave (
    input  attr_addr, rom_req, rom_addr,
    output attr_data, rom_valid, rom_data
  );
endinterface

// File: rtl/sprite_line_engine.sv
// Per-scanline sprite evaluator: scans attribute RAM, fetches pattern rows for
// hits and draws them into the back half of a double line buffer.
module sprite_line_engine #(
  parameter int NUM_SPRITES  = 64,
  parameter int PLANES       = 4,
  parameter int COLOR_W      = 4,
  parameter int HPOS_W       = 9,
  parameter int MAX_PER_LINE = 16
) (
  input  logic                        pixel_clk,
  input  logic                        SPR_ROM_ADDR_RST,
  input  logic                        i_line_start,
  input  logic [7:0]                  i_vline,
  input  logic [HPOS_W-1:0]           i_hpix,
  output logic [PLANES+COLOR_W-1:0]   o_pixel_out,
  output logic                        o_busy,
  output logic                        o_overflow,
  sprite_line_engine_if.master        bus
);
  localparam int PW    = $clog2(NUM_SPRITES);
  localparam int PIX_W = PLANES + COLOR_W;
  localparam int DEPTH = 1 << HPOS_W;
  localparam int CNT_W = $clog2(MAX_PER_LINE + 1);

  typedef enum logic [3:0] {
    IDLE, RD_VPOS, RD_IDX, RD_XDAT, RD_HPOS, CHECK, FETCH, DRAW, NEXT, DONE
  } state_t;

  state_t              r_state, w_next;
  logic                r_ph;
  logic [PW-1:0]       r_ptr;
  logic [CNT_W-1:0]    r_hits;
  logic [7:0]          r_vline;
  logic [7:0]          r_vpos;
  logic [9:0]          r_idx;
  logic [COLOR_W-1:0]  r_color;
  logic                r_hflip;
  logic                r_hpos_hi;
  logic [HPOS_W-1:0]   r_hpos;
  logic [3:0]          r_row;
  logic                r_k;
  logic [2:0]          r_pix;
  logic [PLANES*8-1:0] r_rom;
  logic                r_fsel;
  logic                r_ovf_pend;
  logic [PIX_W-1:0]    r_lbuf [2][DEPTH];

  logic [7:0]          w_diff;
  logic                w_hit;
  logic                w_cap;
  logic [1:0]          w_bsel;
  logic [2:0]          w_bit;
  logic [7:0]          w_pb;
  logic [PLANES-1:0]   w_planes;
  logic [HPOS_W-1:0]   w_waddr;
  logic                w_we;

  assign w_diff = r_vline - r_vpos;
  assign w_hit  = (w_diff[7:4] == 4'd0);
  assign w_cap  = (r_hits == CNT_W'(MAX_PER_LINE));

  always_ff @(posedge pixel_clk or posedge SPR_ROM_ADDR_RST) begin
    if (SPR_ROM_ADDR_RST) r_state <= IDLE;
    else                  r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      RD_VPOS: if (r_ph) w_next = RD_IDX;
      RD_IDX:  if (r_ph) w_next = RD_XDAT;
      RD_XDAT: if (r_ph) w_next = RD_HPOS;
      RD_HPOS: if (r_ph) w_next = CHECK;
      CHECK:   if (!w_hit)    w_next = NEXT;
               else if (w_cap) w_next = DONE;
               else            w_next = FETCH;
      FETCH:   if (bus.rom_valid) w_next = DRAW;
      DRAW:    if (r_pix == 3'd7) w_next = r_k ? NEXT : FETCH;
      NEXT:    w_next = (r_ptr == PW'(NUM_SPRITES - 1)) ? DONE : RD_VPOS;
      DONE:    w_next = IDLE;
      default: w_next = r_state;
    endcase
    // A new line always wins, aborting whatever scan is in flight.
    if (i_line_start) w_next = RD_VPOS;
  end

  always_comb begin
    w_bsel = 2'd0;
    case (r_state)
      RD_IDX:  w_bsel = 2'd1;
      RD_XDAT: w_bsel = 2'd2;
      RD_HPOS: w_bsel = 2'd3;
      default: w_bsel = 2'd0;
    endcase
  end

  assign bus.attr_addr = (r_state == IDLE) ? '0 : {r_ptr, w_bsel};
  assign bus.rom_req   = (r_state == FETCH);
  assign bus.rom_addr  = {r_idx, r_row, r_k ^ r_hflip};
  assign o_busy        = (r_state != IDLE) && (r_state != DONE);

  always_ff @(posedge pixel_clk or posedge SPR_ROM_ADDR_RST) begin
    if (SPR_ROM_ADDR_RST) begin
      r_ph       <= 1'b0;
      r_ptr      <= '0;
      r_hits     <= '0;
      r_vline    <= '0;
      r_vpos     <= '0;
      r_idx      <= '0;
      r_color    <= '0;
      r_hflip    <= 1'b0;
      r_hpos_hi  <= 1'b0;
      r_hpos     <= '0;
      r_row      <= '0;
      r_k        <= 1'b0;
      r_pix      <= '0;
      r_rom      <= '0;
      r_fsel     <= 1'b0;
      r_ovf_pend <= 1'b0;
      o_overflow <= 1'b0;
    end else if (i_line_start) begin
      r_fsel     <= ~r_fsel;
      o_overflow <= r_ovf_pend | o_busy;
      r_ovf_pend <= 1'b0;
      r_vline    <= i_vline;
      r_ptr      <= '0;
      r_hits     <= '0;
      r_ph       <= 1'b0;
      r_k        <= 1'b0;
      r_pix      <= '0;
    end else begin
      case (r_state)
        RD_VPOS, RD_IDX, RD_XDAT, RD_HPOS: begin
          // Phase 0 presents the address, phase 1 sees the RAM data.
          r_ph <= ~r_ph;
          if (r_ph) begin
            if (r_state == RD_VPOS) r_vpos <= bus.attr_data;
            if (r_state == RD_IDX)  r_idx[7:0] <= bus.attr_data;
            if (r_state == RD_XDAT) begin
              r_idx[9:8] <= bus.attr_data[7:6];
              r_hflip    <= bus.attr_data[5];
              r_color    <= COLOR_W'(bus.attr_data[4:1]);
              r_hpos_hi  <= bus.attr_data[0];
            end
            if (r_state == RD_HPOS) r_hpos <= HPOS_W'({r_hpos_hi, bus.attr_data});
          end
        end
        CHECK: begin
          r_row <= w_diff[3:0];
          r_k   <= 1'b0;
          r_pix <= '0;
          if (w_hit && !w_cap) r_hits     <= r_hits + 1'b1;
          if (w_hit && w_cap)  r_ovf_pend <= 1'b1;
        end
        FETCH: if (bus.rom_valid) r_rom <= bus.rom_data;
        DRAW: begin
          r_pix <= r_pix + 3'd1;
          if (r_pix == 3'd7) r_k <= 1'b1;
        end
        NEXT:    r_ptr <= r_ptr + 1'b1;
        default: ;
      endcase
    end
  end

  // Mirrored sprites read the plane byte LSB-first instead of MSB-first.
  assign w_bit = r_hflip ? r_pix : (3'd7 - r_pix);

  always_comb begin
    w_planes = '0;
    w_pb     = '0;
    for (int p = 0; p < PLANES; p++) begin
      w_pb        = r_rom[p*8 +: 8];
      w_planes[p] = w_pb[w_bit];
    end
  end

  assign w_waddr = r_hpos + HPOS_W'({r_k, r_pix});
  assign w_we    = (r_state == DRAW) && (|w_planes) && !i_line_start;

  // Draw and clear-on-read always target opposite halves, so they never collide.
  always_ff @(posedge pixel_clk) begin
    if (w_we) r_lbuf[~r_fsel][w_waddr] <= {r_color, w_planes};
    r_lbuf[r_fsel][i_hpix] <= '0;
  end

  always_ff @(posedge pixel_clk or posedge SPR_ROM_ADDR_RST) begin
    if (SPR_ROM_ADDR_RST) o_pixel_out <= '0;
    else                  o_pixel_out <= r_lbuf[r_fsel][i_hpix];
  end
endmodule

// File: tb/tb_sprite_line_engine.sv
// Directed bench for sprite_line_engine: attribute RAM and pattern ROM models,
// table-driven read-out checks plus hand-written overflow/abort/reset sequences.
module tb_sprite_line_engine;
  localparam int NS = 64, PL = 4, CW = 4, HW = 9, MPL = 16, AW = 8;
  localparam logic [8:0] IDLE_HP = 9'h1F0;

  logic        pixel_clk = 1'b0;
  logic        rst;
  logic        line_start;
  logic [7:0]  vline;
  logic [8:0]  hpix;
  logic [7:0]  pixel_out;
  logic        busy, overflow;

  sprite_line_engine_if #(.AW(AW), .PLANES(PL)) bus ();

  sprite_line_engine #(
    .NUM_SPRITES(NS), .PLANES(PL), .COLOR_W(CW), .HPOS_W(HW), .MAX_PER_LINE(MPL)
  ) dut (
    .pixel_clk        (pixel_clk),
    .SPR_ROM_ADDR_RST (rst),
    .i_line_start     (line_start),
    .i_vline          (vline),
    .i_hpix           (hpix),
    .o_pixel_out      (pixel_out),
    .o_busy           (busy),
    .o_overflow       (overflow),
    .bus              (bus)
  );

  always #5 pixel_clk = ~pixel_clk;

  int n_chk = 0, n_fail = 0;

  // Attribute RAM: address seen during cycle c, data valid during c+1.
  logic [7:0] attr_mem [256];
  logic [7:0] a_q;
  initial begin
    bus.attr_data = '0;
    forever begin
      @(negedge pixel_clk); a_q = bus.attr_addr;
      @(posedge pixel_clk); #1 bus.attr_data = attr_mem[a_q];
    end
  end

  // Pattern ROM: answers a held request on its third cycle.
  logic [14:0] rom_log [$];
  logic [31:0] rom_h0, rom_h1;
  logic [9:0]  zero_idx;
  logic        zero_en;
  int          rcnt;
  initial begin
    bus.rom_valid = 1'b0; bus.rom_data = '0; rcnt = 0;
    forever begin
      @(posedge pixel_clk); #1;
      if (bus.rom_valid) begin
        bus.rom_valid = 1'b0; rcnt = 0;
      end else if (bus.rom_req) begin
        rcnt++;
        if (rcnt == 1) rom_log.push_back(bus.rom_addr);
        if (rcnt == 3) begin
          bus.rom_valid = 1'b1;
          bus.rom_data  = (zero_en && bus.rom_addr[14:5] == zero_idx) ? 32'h0 :
                          (bus.rom_addr[0] ? rom_h1 : rom_h0);
        end
      end else rcnt = 0;
    end
  end

  typedef struct { int tid; logic [8:0] hp; logic [7:0] exp; } rd_vec_t;
  rd_vec_t vt [$];

  function automatic void addv(int t, logic [8:0] h, logic [7:0] e);
    rd_vec_t v;
    v.tid = t; v.hp = h; v.exp = e;
    vt.push_back(v);
  endfunction

  function automatic logic [14:0] logged(int i);
    return (rom_log.size() > i) ? rom_log[i] : 15'h7FFF;
  endfunction

  task automatic tick; @(posedge pixel_clk); #1; endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pulse_ls(input logic [7:0] v);
    vline = v; line_start = 1'b1; tick; line_start = 1'b0;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (busy && n < 5000) begin tick; n++; end
    check("wait_idle_busy", busy, 0);
  endtask

  task automatic blank_ram;
    for (int i = 0; i < 256; i++) attr_mem[i] = (i % 4 == 0) ? 8'h80 : 8'h00;
  endtask

  task automatic set_spr(input int n, input logic [7:0] b0, b1, b2, b3);
    attr_mem[4*n] = b0; attr_mem[4*n+1] = b1; attr_mem[4*n+2] = b2; attr_mem[4*n+3] = b3;
  endtask

  task automatic sweep;
    for (int a = 0; a < 512; a++) begin hpix = 9'(a); tick; end
    hpix = IDLE_HP;
  endtask

  // Two blank lines with full sweeps leave both buffer halves clear.
  task automatic prep;
    wait_idle; blank_ram;
    pulse_ls(8'h23); sweep; wait_idle;
    pulse_ls(8'h23); sweep; wait_idle;
  endtask

  task automatic run_rd(input int tid);
    foreach (vt[j]) if (vt[j].tid == tid) begin
      hpix = vt[j].hp; tick;
      check($sformatf("t%0d_hpix_%0h", tid, vt[j].hp), pixel_out, vt[j].exp);
    end
    hpix = IDLE_HP;
  endtask

  task automatic build_and_show(input logic [7:0] v);
    pulse_ls(v); wait_idle; pulse_ls(v);
  endtask

  initial begin
    // t1: plain sprite, color 1, plane0 solid; last entry is the clear-on-read repeat
    addv(1, 9'h00F, 8'h00); addv(1, 9'h010, 8'h11); addv(1, 9'h017, 8'h11);
    addv(1, 9'h018, 8'h11); addv(1, 9'h01F, 8'h11); addv(1, 9'h020, 8'h00);
    addv(1, 9'h010, 8'h00);
    // t2: hflip, plane0 = 0x80 on both halves
    addv(2, 9'h010, 8'h00); addv(2, 9'h016, 8'h00); addv(2, 9'h017, 8'h11);
    addv(2, 9'h018, 8'h00); addv(2, 9'h01E, 8'h00); addv(2, 9'h01F, 8'h11);
    // t3: overlap, later sprite wins; t4: later sprite transparent
    addv(3, 9'h010, 8'h21); addv(3, 9'h01F, 8'h21);
    addv(4, 9'h010, 8'h11); addv(4, 9'h01F, 8'h11);
    // t5: wrap-around at HPOS 0x1FC
    addv(5, 9'h1FB, 8'h00); addv(5, 9'h1FC, 8'h11); addv(5, 9'h1FF, 8'h11);
    addv(5, 9'h000, 8'h11); addv(5, 9'h00B, 8'h11); addv(5, 9'h00C, 8'h00);
    // t6: 20 hits, only sprites 0..15 drawn
    addv(6, 9'h000, 8'h11); addv(6, 9'h0F0, 8'h11); addv(6, 9'h0FF, 8'h11);
    addv(6, 9'h100, 8'h00); addv(6, 9'h13F, 8'h00);

    rst = 1'b1; line_start = 1'b0; vline = '0; hpix = IDLE_HP;
    zero_en = 1'b0; zero_idx = '0; rom_h0 = 32'hFF; rom_h1 = 32'hFF;
    blank_ram;
    repeat (3) tick;
    check("rst_pixel_out", pixel_out, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_rom_req", bus.rom_req, 0);
    check("rst_attr_addr", bus.attr_addr, 0);
    rst = 1'b0; tick;

    prep;
    set_spr(0, 8'h20, 8'h05, 8'h02, 8'h10);
    rom_log.delete();
    pulse_ls(8'h23); wait_idle;
    check("t1_nfetch", rom_log.size(), 2);
    check("t1_rom_addr0", logged(0), 15'h00A6);
    check("t1_rom_addr1", logged(1), 15'h00A7);
    pulse_ls(8'h23);
    check("t1_overflow", overflow, 0);
    run_rd(1);

    prep;
    set_spr(0, 8'h20, 8'h05, 8'h22, 8'h10);
    rom_h0 = 32'h80; rom_h1 = 32'h80; rom_log.delete();
    pulse_ls(8'h23); wait_idle;
    check("t2_rom_addr0", logged(0), 15'h00A7);
    check("t2_rom_addr1", logged(1), 15'h00A6);
    pulse_ls(8'h23);
    run_rd(2);

    prep;
    rom_h0 = 32'hFF; rom_h1 = 32'hFF;
    set_spr(0, 8'h20, 8'h05, 8'h02, 8'h10);
    set_spr(1, 8'h20, 8'h06, 8'h04, 8'h10);
    build_and_show(8'h23);
    run_rd(3);

    prep;
    set_spr(0, 8'h20, 8'h05, 8'h02, 8'h10);
    set_spr(1, 8'h20, 8'h06, 8'h04, 8'h10);
    zero_en = 1'b1; zero_idx = 10'h006;
    build_and_show(8'h23);
    run_rd(4);
    zero_en = 1'b0;

    prep;
    set_spr(0, 8'h20, 8'h05, 8'h03, 8'hFC);
    build_and_show(8'h23);
    run_rd(5);

    prep;
    for (int n = 0; n < 20; n++)
      set_spr(n, 8'h20, 8'h05, (n >= 16) ? 8'h03 : 8'h02, 8'((n * 16) & 255));
    rom_log.delete();
    pulse_ls(8'h23); wait_idle;
    check("t6_nfetch", rom_log.size(), 32);
    pulse_ls(8'h23);
    check("t6_overflow", overflow, 1);
    run_rd(6);
    prep;
    check("t6_clean_overflow", overflow, 0);

    // Abort: second line_start lands mid-scan.
    pulse_ls(8'h23);
    repeat (40) tick;
    check("abort_busy_mid", busy, 1);
    pulse_ls(8'h23);
    check("abort_attr_addr", bus.attr_addr, 0);
    check("abort_busy", busy, 1);
    check("abort_overflow", overflow, 1);
    wait_idle;
    pulse_ls(8'h23);
    check("abort_next_overflow", overflow, 0);
    wait_idle;

    // Reset while a fetch is outstanding.
    set_spr(0, 8'h20, 8'h05, 8'h02, 8'h10);
    pulse_ls(8'h23);
    begin
      int n = 0;
      while (!bus.rom_req && n < 300) begin tick; n++; end
    end
    check("rstmid_req_seen", bus.rom_req, 1);
    rst = 1'b1; #1;
    check("rstmid_rom_req", bus.rom_req, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_overflow", overflow, 0);
    check("rstmid_attr_addr", bus.attr_addr, 0);
    check("rstmid_pixel_out", pixel_out, 0);
    tick; rst = 1'b0; tick;
    check("rstmid_still_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
